// File: rtl/ddr3_arb_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arb_pkg
// Shared definitions for the two-port DDR3 MIF arbiter.
//   CMD_WR / CMD_RD : MIF command codes the arbiter understands
//   BURST_W         : width of the burst count (app_burst_number)
//   arb_state_t     : transaction-level arbiter state
// ---------------------------------------------------------------------------
package ddr3_arb_pkg;

    localparam int         BURST_W = 6;
    localparam logic [2:0] CMD_WR  = 3'b000;
    localparam logic [2:0] CMD_RD  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_priority_sel.sv
// ---------------------------------------------------------------------------
// arb_priority_sel
// Combinational winner select between the display (port 0) and render
// (port 1) requesters. Port 0 wins unless port 1 is also requesting and has
// been starved long enough.
//   req0, req1 : command-valid of each port
//   starve     : port 1 has waited through the allowed number of grants
//   win        : one-hot winner, 2'b00 when nobody requests
// ---------------------------------------------------------------------------
module arb_priority_sel (
    input  logic       req0,
    input  logic       req1,
    input  logic       starve,
    output logic [1:0] win
);

    // Fixed priority with a starvation override for port 1.
    always_comb begin
        win = 2'b00;
        if (req0 && !(req1 && starve)) begin
            win = 2'b01;
        end else if (req1) begin
            win = 2'b10;
        end else begin
            win = 2'b00;
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_port_arbiter
// Shares one DDR3 MIF user interface between port 0 (display reads, priority)
// and port 1 (render writes). Whole transactions are serialised: one command,
// then all of its data beats. Nothing is granted before calibration.
//   hclk, hresetn          : MIF user clock, async active-low reset
//   calib_done             : MIF init_calib_complete
//   pN_cmd/addr/bursts     : per-port command fields, pN_cmd_valid/ready
//   pN_wr_*                : per-port write beat channel (pass-through)
//   pN_rd_*                : per-port read beat channel (no backpressure)
//   mem_*                  : MIF-side command / write / read channels
//   grant                  : one-hot owner, 2'b00 when idle
//   err                    : sticky protocol error (cleared only by reset)
// ---------------------------------------------------------------------------
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic                calib_done,
    input  logic [2:0]          p0_cmd,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [BURST_W-1:0]  p0_bursts,
    input  logic                p0_cmd_valid,
    output logic                p0_cmd_ready,
    input  logic [DATA_W-1:0]   p0_wr_data,
    input  logic [DATA_W/8-1:0] p0_wr_strb,
    input  logic                p0_wr_valid,
    output logic                p0_wr_ready,
    output logic [DATA_W-1:0]   p0_rd_data,
    output logic                p0_rd_valid,
    output logic                p0_rd_last,
    input  logic [2:0]          p1_cmd,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [BURST_W-1:0]  p1_bursts,
    input  logic                p1_cmd_valid,
    output logic                p1_cmd_ready,
    input  logic [DATA_W-1:0]   p1_wr_data,
    input  logic [DATA_W/8-1:0] p1_wr_strb,
    input  logic                p1_wr_valid,
    output logic                p1_wr_ready,
    output logic [DATA_W-1:0]   p1_rd_data,
    output logic                p1_rd_valid,
    output logic                p1_rd_last,
    output logic [2:0]          mem_cmd,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BURST_W-1:0]  mem_bursts,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic [DATA_W/8-1:0] mem_wr_strb,
    output logic                mem_wr_valid,
    output logic                mem_wr_last,
    input  logic                mem_wr_ready,
    input  logic [DATA_W-1:0]   mem_rd_data,
    input  logic                mem_rd_valid,
    output logic [1:0]          grant,
    output logic                err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          state_r;
    logic [1:0]          grant_r;
    logic                err_r;
    logic [CNT_W-1:0]    starve_cnt_r;
    logic [BURST_W-1:0]  beat_cnt_r;
    logic [2:0]          cmd_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [BURST_W-1:0]  bursts_r;
    logic                cmd_valid_r;

    logic [1:0]          win_s;
    logic                arb_en_s;
    logic                wr_act_s;
    logic                rd_act_s;
    logic                beat_last_s;
    logic                wr_fire_s;
    logic                rd_fire_s;

    arb_priority_sel u_sel (
        .req0   (p0_cmd_valid),
        .req1   (p1_cmd_valid),
        .starve (starve_cnt_r == CNT_W'(STARVE_LIMIT)),
        .win    (win_s)
    );

    // Data phases only pass traffic while calibration holds, so an abort
    // stops forwarding in the very cycle calib_done falls.
    assign arb_en_s    = (state_r == ST_IDLE)  && calib_done;
    assign wr_act_s    = (state_r == ST_WDATA) && calib_done;
    assign rd_act_s    = (state_r == ST_RDATA) && calib_done;
    assign beat_last_s = (beat_cnt_r == bursts_r);

    // The ready pulse coincides with the capture edge, forming a true handshake.
    assign p0_cmd_ready = arb_en_s && win_s[0];
    assign p1_cmd_ready = arb_en_s && win_s[1];

    assign grant         = grant_r;
    assign err           = err_r;
    assign mem_cmd       = cmd_r;
    assign mem_addr      = addr_r;
    assign mem_bursts    = bursts_r;
    assign mem_cmd_valid = cmd_valid_r;

    // Write channel pass-through from the current owner.
    always_comb begin
        if (wr_act_s) begin
            mem_wr_valid = grant_r[1] ? p1_wr_valid : p0_wr_valid;
            mem_wr_data  = grant_r[1] ? p1_wr_data  : p0_wr_data;
            mem_wr_strb  = grant_r[1] ? p1_wr_strb  : p0_wr_strb;
            p0_wr_ready  = grant_r[0] && mem_wr_ready;
            p1_wr_ready  = grant_r[1] && mem_wr_ready;
        end else begin
            mem_wr_valid = 1'b0;
            mem_wr_data  = {DATA_W{1'b0}};
            mem_wr_strb  = {(DATA_W/8){1'b0}};
            p0_wr_ready  = 1'b0;
            p1_wr_ready  = 1'b0;
        end
    end

    assign mem_wr_last = mem_wr_valid && beat_last_s;
    assign wr_fire_s   = mem_wr_valid && mem_wr_ready;

    // Read beats are routed with zero latency; the non-owner sees zeros.
    assign p0_rd_valid = rd_act_s && grant_r[0] && mem_rd_valid;
    assign p1_rd_valid = rd_act_s && grant_r[1] && mem_rd_valid;
    assign p0_rd_data  = p0_rd_valid ? mem_rd_data : {DATA_W{1'b0}};
    assign p1_rd_data  = p1_rd_valid ? mem_rd_data : {DATA_W{1'b0}};
    assign p0_rd_last  = p0_rd_valid && beat_last_s;
    assign p1_rd_last  = p1_rd_valid && beat_last_s;
    assign rd_fire_s   = rd_act_s && mem_rd_valid;

    // Transaction FSM: arbitration, command issue, beat counting and aborts.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= ST_IDLE;
            grant_r     <= 2'b00;
            err_r       <= 1'b0;
            beat_cnt_r  <= {BURST_W{1'b0}};
            cmd_r       <= 3'b000;
            addr_r      <= {ADDR_W{1'b0}};
            bursts_r    <= {BURST_W{1'b0}};
            cmd_valid_r <= 1'b0;
        end else begin
            // Read data the arbiter did not ask for is dropped and flagged.
            if (mem_rd_valid && (state_r != ST_RDATA)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (arb_en_s && (win_s != 2'b00)) begin
                        cmd_r       <= win_s[1] ? p1_cmd    : p0_cmd;
                        addr_r      <= win_s[1] ? p1_addr   : p0_addr;
                        bursts_r    <= win_s[1] ? p1_bursts : p0_bursts;
                        grant_r     <= win_s;
                        cmd_valid_r <= 1'b1;
                        state_r     <= ST_CMD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (!calib_done) begin
                        cmd_valid_r <= 1'b0;
                        grant_r     <= 2'b00;
                        err_r       <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (mem_cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        beat_cnt_r  <= {BURST_W{1'b0}};
                        case (cmd_r)
                            CMD_WR:  state_r <= ST_WDATA;
                            CMD_RD:  state_r <= ST_RDATA;
                            default: begin
                                err_r   <= 1'b1;
                                grant_r <= 2'b00;
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_CMD;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    if (!calib_done) begin
                        grant_r <= 2'b00;
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (wr_fire_s || rd_fire_s) begin
                        if (beat_last_s) begin
                            grant_r <= 2'b00;
                            state_r <= ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 6'd1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    grant_r     <= 2'b00;
                    cmd_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Count port-0 grants that port 1 sat through; any gap in its request resets it.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (!p1_cmd_valid) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (p0_cmd_ready) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
        end else if (p1_cmd_ready) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
module tb_ddr3_port_arbiter;
    import ddr3_arb_pkg::*;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int STRB_W = DATA_W / 8;

    logic               hclk = 1'b0;
    logic               hresetn, calib_done;
    logic [2:0]         p0_cmd, p1_cmd, mem_cmd;
    logic [ADDR_W-1:0]  p0_addr, p1_addr, mem_addr;
    logic [5:0]         p0_bursts, p1_bursts, mem_bursts;
    logic               p0_cmd_valid, p0_cmd_ready, p1_cmd_valid, p1_cmd_ready;
    logic [DATA_W-1:0]  p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
    logic [STRB_W-1:0]  p0_wr_strb, p1_wr_strb, mem_wr_strb;
    logic               p0_wr_valid, p0_wr_ready, p1_wr_valid, p1_wr_ready;
    logic               p0_rd_valid, p0_rd_last, p1_rd_valid, p1_rd_last;
    logic               mem_cmd_valid, mem_cmd_ready;
    logic [DATA_W-1:0]  mem_wr_data, mem_rd_data;
    logic               mem_wr_valid, mem_wr_last, mem_wr_ready, mem_rd_valid;
    logic [1:0]         grant;
    logic               err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 hclk = ~hclk;

    ddr3_port_arbiter dut (
        .hclk(hclk), .hresetn(hresetn), .calib_done(calib_done),
        .p0_cmd(p0_cmd), .p0_addr(p0_addr), .p0_bursts(p0_bursts),
        .p0_cmd_valid(p0_cmd_valid), .p0_cmd_ready(p0_cmd_ready),
        .p0_wr_data(p0_wr_data), .p0_wr_strb(p0_wr_strb),
        .p0_wr_valid(p0_wr_valid), .p0_wr_ready(p0_wr_ready),
        .p0_rd_data(p0_rd_data), .p0_rd_valid(p0_rd_valid), .p0_rd_last(p0_rd_last),
        .p1_cmd(p1_cmd), .p1_addr(p1_addr), .p1_bursts(p1_bursts),
        .p1_cmd_valid(p1_cmd_valid), .p1_cmd_ready(p1_cmd_ready),
        .p1_wr_data(p1_wr_data), .p1_wr_strb(p1_wr_strb),
        .p1_wr_valid(p1_wr_valid), .p1_wr_ready(p1_wr_ready),
        .p1_rd_data(p1_rd_data), .p1_rd_valid(p1_rd_valid), .p1_rd_last(p1_rd_last),
        .mem_cmd(mem_cmd), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_addr(mem_addr), .mem_bursts(mem_bursts),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .mem_wr_valid(mem_wr_valid), .mem_wr_last(mem_wr_last), .mem_wr_ready(mem_wr_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .grant(grant), .err(err)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  k;
        int  acc;
        int  lastpos;
        int  gcnt;
        logic ok;
        int  seq [10];
        int  exp_seq [10];
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) seq[i] = 9;

        hresetn = 1'b0; calib_done = 1'b0;
        p0_cmd = 3'b000; p0_addr = 28'h0; p0_bursts = 6'd0; p0_cmd_valid = 1'b0;
        p1_cmd = 3'b000; p1_addr = 28'h0; p1_bursts = 6'd0; p1_cmd_valid = 1'b0;
        p0_wr_data = 128'h0; p0_wr_strb = 16'h0; p0_wr_valid = 1'b0;
        p1_wr_data = 128'h0; p1_wr_strb = 16'h0; p1_wr_valid = 1'b0;
        mem_cmd_ready = 1'b0; mem_wr_ready = 1'b0;
        mem_rd_data = 128'h0; mem_rd_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_cmd_valid", 128'(mem_cmd_valid), 128'd0);
        chk("rst_wr_valid", 128'(mem_wr_valid), 128'd0);
        chk("rst_addr", 128'(mem_addr), 128'd0);
        hresetn = 1'b1;
        tick();

        // No grant before calibration, even with a pending p0 read
        p0_cmd = CMD_RD; p0_addr = 28'h40; p0_bursts = 6'd1; p0_cmd_valid = 1'b1;
        ok = 1'b1;
        repeat (100) begin
            tick();
            if (grant !== 2'b00 || mem_cmd_valid !== 1'b0 || p0_cmd_ready !== 1'b0) ok = 1'b0;
        end
        chk("nocal_blocked", 128'(ok), 128'd1);
        calib_done = 1'b1;
        #1;
        chk("cal_p0_ready", 128'(p0_cmd_ready), 128'd1);
        tick();
        p0_cmd_valid = 1'b0;
        chk("cal_grant", 128'(grant), 128'd1);
        chk("cal_cmd_valid", 128'(mem_cmd_valid), 128'd1);
        chk("cal_cmd", 128'(mem_cmd), 128'd1);
        chk("cal_addr", 128'(mem_addr), 128'h40);
        tick();
        chk("cmd_hold", 128'(mem_cmd_valid), 128'd1);
        mem_cmd_ready = 1'b1;
        tick();
        chk("cmd_done", 128'(mem_cmd_valid), 128'd0);

        // p0 read, 2 beats
        mem_rd_valid = 1'b1; mem_rd_data = 128'hA1;
        #1;
        chk("rd0_valid", 128'(p0_rd_valid), 128'd1);
        chk("rd0_data", p0_rd_data, 128'hA1);
        chk("rd0_last", 128'(p0_rd_last), 128'd0);
        chk("rd0_p1_valid", 128'(p1_rd_valid), 128'd0);
        tick();
        mem_rd_data = 128'hB2;
        #1;
        chk("rd1_data", p0_rd_data, 128'hB2);
        chk("rd1_last", 128'(p0_rd_last), 128'd1);
        chk("rd1_p1_valid", 128'(p1_rd_valid), 128'd0);
        tick();
        mem_rd_valid = 1'b0;
        chk("rd_end_grant", 128'(grant), 128'd0);
        chk("rd_end_err", 128'(err), 128'd0);

        // 64-beat read (bursts = 63)
        p0_bursts = 6'd63; p0_cmd_valid = 1'b1;
        tick();
        p0_cmd_valid = 1'b0;
        tick();
        acc = 0; lastpos = -1;
        mem_rd_valid = 1'b1;
        for (int i = 0; i < 70 && grant != 2'b00; i++) begin
            mem_rd_data = 128'(i);
            #1;
            if (p0_rd_valid) begin
                if (p0_rd_last) lastpos = acc;
                acc++;
            end
            tick();
        end
        mem_rd_valid = 1'b0;
        chk("b64_beats", 128'(acc), 128'd64);
        chk("b64_lastpos", 128'(lastpos), 128'd63);
        chk("b64_grant", 128'(grant), 128'd0);

        // p1 write, 4 beats with toggling mem_wr_ready
        p1_cmd = CMD_WR; p1_addr = 28'h100; p1_bursts = 6'd3; p1_cmd_valid = 1'b1;
        #1;
        chk("wr_p1_ready", 128'(p1_cmd_ready), 128'd1);
        chk("wr_p0_ready", 128'(p0_cmd_ready), 128'd0);
        tick();
        p1_cmd_valid = 1'b0;
        chk("wr_grant", 128'(grant), 128'd2);
        chk("wr_addr", 128'(mem_addr), 128'h100);
        chk("wr_bursts", 128'(mem_bursts), 128'd3);
        chk("wr_cmd", 128'(mem_cmd), 128'd0);
        tick();
        k = 0; ok = 1'b1;
        p1_wr_valid = 1'b1; p1_wr_strb = 16'h0F0F;
        for (int c = 0; c < 20 && k < 4; c++) begin
            mem_wr_ready = c[0];
            p1_wr_data = 128'(k) + 128'h500;
            #1;
            if (p0_wr_ready !== 1'b0 || mem_wr_valid !== 1'b1 || mem_wr_strb !== 16'h0F0F) ok = 1'b0;
            if (mem_wr_ready) begin
                if (mem_wr_data !== 128'(k) + 128'h500 || mem_wr_last !== (k == 3) || p1_wr_ready !== 1'b1) ok = 1'b0;
                k++;
            end else if (p1_wr_ready !== 1'b0) begin
                ok = 1'b0;
            end
            tick();
        end
        p1_wr_valid = 1'b0; mem_wr_ready = 1'b1;
        chk("wr_beats_ok", 128'(ok), 128'd1);
        chk("wr_beat_cnt", 128'(k), 128'd4);
        chk("wr_end_grant", 128'(grant), 128'd0);
        chk("wr_end_valid", 128'(mem_wr_valid), 128'd0);

        // Starvation: both ports requesting continuously
        p0_cmd = CMD_WR; p0_addr = 28'h10; p0_bursts = 6'd0;
        p1_cmd = CMD_WR; p1_addr = 28'h20; p1_bursts = 6'd0;
        p0_wr_valid = 1'b1; p1_wr_valid = 1'b1;
        p0_cmd_valid = 1'b1; p1_cmd_valid = 1'b1;
        gcnt = 0;
        for (int c = 0; c < 60 && gcnt < 10; c++) begin
            #1;
            if (p0_cmd_ready) begin
                seq[gcnt] = 0; gcnt++;
            end else if (p1_cmd_ready) begin
                seq[gcnt] = 1; gcnt++;
            end
            tick();
        end
        p0_cmd_valid = 1'b0; p1_cmd_valid = 1'b0;
        chk("starve_grants", 128'(gcnt), 128'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), 128'(seq[i]), 128'(exp_seq[i]));
        repeat (3) tick();
        p0_wr_valid = 1'b0; p1_wr_valid = 1'b0;
        chk("starve_end_grant", 128'(grant), 128'd0);
        chk("starve_end_err", 128'(err), 128'd0);

        // Spurious read beat in IDLE
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        chk("spur_err", 128'(err), 128'd1);
        repeat (5) tick();
        chk("spur_sticky", 128'(err), 128'd1);
        hresetn = 1'b0;
        #1;
        chk("spur_rst_clear", 128'(err), 128'd0);
        tick();
        hresetn = 1'b1;

        // Calibration loss mid-write after 2 of 8 beats
        p0_cmd = CMD_WR; p0_addr = 28'h200; p0_bursts = 6'd7; p0_cmd_valid = 1'b1;
        tick();
        p0_cmd_valid = 1'b0;
        tick();
        p0_wr_valid = 1'b1; mem_wr_ready = 1'b1;
        tick();
        tick();
        chk("abort_pre_grant", 128'(grant), 128'd1);
        calib_done = 1'b0;
        #1;
        chk("abort_ready_now", 128'(p0_wr_ready), 128'd0);
        tick();
        chk("abort_grant", 128'(grant), 128'd0);
        chk("abort_err", 128'(err), 128'd1);
        chk("abort_wr_ready", 128'(p0_wr_ready), 128'd0);
        chk("abort_wr_valid", 128'(mem_wr_valid), 128'd0);
        p0_wr_valid = 1'b0; calib_done = 1'b1;

        // Unknown command code
        hresetn = 1'b0; #1; hresetn = 1'b1;
        p0_cmd = 3'b010; p0_bursts = 6'd0; p0_cmd_valid = 1'b1;
        tick();
        p0_cmd_valid = 1'b0;
        chk("badcmd_grant", 128'(grant), 128'd1);
        tick();
        chk("badcmd_idle", 128'(grant), 128'd0);
        chk("badcmd_err", 128'(err), 128'd1);

        // Asynchronous reset mid-transaction
        hresetn = 1'b0; #1; hresetn = 1'b1;
        mem_cmd_ready = 1'b0;
        p1_cmd = CMD_RD; p1_cmd_valid = 1'b1;
        tick();
        p1_cmd_valid = 1'b0;
        chk("arst_pre_valid", 128'(mem_cmd_valid), 128'd1);
        #2;
        hresetn = 1'b0;
        #1;
        chk("arst_grant", 128'(grant), 128'd0);
        chk("arst_cmd_valid", 128'(mem_cmd_valid), 128'd0);
        hresetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_port_arbiter.md
Name: ddr3_port_arbiter

Overview:
- Shares the single DDR3 MIF user interface (cmd/addr/wr_data/rd_data, app_burst_number) between two VDMA-class requesters.
- Port 0 is the display read path and has priority; port 1 is the render write path.
- Sits between the video DMA engines and ddr3_mif, in the MIF user clock domain.
- Serialises whole transactions: a command, then all of its data beats. Routes read data back to the granted port and blocks all traffic until calibration completes.

Parameters:
- ADDR_W, 28, MIF address width.
- DATA_W, 128, MIF data beat width (one beat per BL8).
- STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits; the next grant then goes to port 1.

Ports:
- hclk  in  1  MIF user clock (clk_out of the MIF).
- hresetn  in  1  reset, asynchronous, active-low.
- calib_done  in  1  init_calib_complete from MIF.
- pN_cmd  in  3  command for port N (N=0,1); read=3'b001, write=3'b000.
- pN_addr  in  ADDR_W  start address.
- pN_bursts  in  6  burst count minus 1 (beats = pN_bursts+1).
- pN_cmd_valid / pN_cmd_ready  in/out  1  command handshake.
- pN_wr_data  in  DATA_W  write beat.
- pN_wr_strb  in  DATA_W/8  write mask.
- pN_wr_valid / pN_wr_ready  in/out  1  write beat handshake.
- pN_rd_data  out  DATA_W  read beat.
- pN_rd_valid  out  1  read beat strobe (no backpressure).
- pN_rd_last  out  1  final beat of the transaction.
- mem_cmd  out  3  to MIF cmd.
- mem_cmd_valid  out  1  to MIF cmd_en.
- mem_cmd_ready  in  1  from MIF.
- mem_addr  out  ADDR_W  to MIF addr.
- mem_bursts  out  6  to MIF app_burst_number.
- mem_wr_data  out  DATA_W  to MIF.
- mem_wr_strb  out  DATA_W/8  to MIF.
- mem_wr_valid  out  1  to MIF wr_data_en.
- mem_wr_last  out  1  to MIF wr_data_end.
- mem_wr_ready  in  1  from MIF.
- mem_rd_data  in  DATA_W  from MIF.
- mem_rd_valid  in  1  from MIF.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: state IDLE. grant=0, err=0, starve_cnt=0, beat_cnt=0. All valid, ready and last outputs are 0; data outputs are 0.

States:
- IDLE: no grant while calib_done=0.
  - Port 0 wins if p0_cmd_valid, unless p1_cmd_valid and starve_cnt==STARVE_LIMIT.
  - Otherwise port 1 wins if p1_cmd_valid.
  - Register the winner's cmd/addr/bursts and set grant. pN_cmd_ready pulses 1 cycle on the capture edge. Go to CMD.
  - starve_cnt increments on a port-0 grant while p1_cmd_valid=1. It clears on a port-1 grant or when p1_cmd_valid=0.
- CMD: mem_cmd_valid=1 with the registered fields held stable until mem_cmd_ready. Then beat_cnt=0 and go to WDATA (write) or RDATA (read). Any other cmd code sets err and returns to IDLE.
- WDATA:
  - Combinational pass-through: mem_wr_valid=pN_wr_valid, pN_wr_ready=mem_wr_ready, data and strb forwarded from the owner.
  - A beat is accepted on valid&ready; beat_cnt increments on each accepted beat.
  - mem_wr_last=1 on the beat where beat_cnt==bursts. That beat's acceptance goes to IDLE.
  - The non-owner's wr_ready stays 0.
- RDATA:
  - Each mem_rd_valid is forwarded to the owner's rd_valid/rd_data in the same cycle (zero latency); beat_cnt increments.
  - pN_rd_last=1 on the beat where beat_cnt==bursts, then go to IDLE.
- Minimum transaction overhead: 1 cycle in IDLE, then CMD for ≥1 cycle. Back-to-back grants are allowed with no extra idle cycle.

Boundaries:
- mem_rd_valid outside RDATA: set err, drop the beat.
- calib_done falls in any non-IDLE state: abort to IDLE, clear grant, set err. Data already forwarded is not retracted.
- bursts=63 means 64 beats; beat_cnt is 6 bits and compares without wrap.
- Both ports assert valid with starve_cnt<LIMIT: port 0 wins, port 1 keeps waiting and its cmd_ready stays 0.
- Async reset mid-transaction: immediate return to reset values. The MIF is not notified.
- err clears only on reset.

Decomposition:
- Package ddr3_arb_pkg: CMD_WR=3'b000, CMD_RD=3'b001, state encoding (IDLE, CMD, WDATA, RDATA), BURST_W=6.
- One natural sub-module: arb_priority_sel. It is combinational: two valids plus the starve flag in, one-hot winner out.

Test Plan:
- calib_done=0, p0 read valid → no grant, mem_cmd_valid=0 for 100 cycles. Raise calib_done → grant=01 and mem_cmd_valid on the next cycle.
- p1 write, addr=0x100, bursts=3, mem_wr_ready toggling → exactly 4 beats forwarded, mem_wr_last on the 4th, then grant=00.
- p0 read, bursts=1 → 2 mem_rd_valid beats routed to p0 only, p0_rd_last on the 2nd, p1_rd_valid stays 0.
- p0 and p1 valid continuously, STARVE_LIMIT=4 → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Spurious mem_rd_valid in IDLE → err=1 and stays 1 until hresetn is asserted.
- calib_done dropped during WDATA after 2 of 8 beats → state IDLE, err=1, wr_ready low.
